idecoder_pipe: RTL and testbench

Parametrised, buffered successor to the single-cycle instruction decoder. It accepts RV32I instruction words with their PC over a valid/ready handshake, decodes them, and flags illegal encodings. Decoded results go into a parametrised in-order output queue with its own valid/ready handshake. It sits between instruction fetch and the execute/register-read stage and replaces the fixed simulated-delay counter with real backpressure and flush support.

---
 rtl/idecoder_pipe_pkg.sv | 59 +++++
 rtl/idecoder_pipe_if.sv | 43 ++++
 rtl/idecoder_pipe_idecode_core.sv | 137 +++++++++++++
 rtl/idecoder_pipe.sv | 96 +++++++++
 tb/tb_idecoder_pipe.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/idecoder_pipe_pkg.sv
// Shared RV32I decode definitions: opcodes, funct legality constants and
// the decoded-instruction record carried through the output queue.
package idecoder_pipe_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_IMM    = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;

  localparam logic [6:0] F7_BASE       = 7'b0000000;
  localparam logic [6:0] F7_ALT        = 7'b0100000;
  localparam logic [2:0] F3_ADD_SUB    = 3'b000;
  localparam logic [2:0] F3_SLL        = 3'b001;
  localparam logic [2:0] F3_SRL_SRA    = 3'b101;
  localparam logic [2:0] F3_LD_RSVD3   = 3'b011;
  localparam logic [2:0] F3_LD_RSVD6   = 3'b110;
  localparam logic [2:0] F3_LD_RSVD7   = 3'b111;
  localparam logic [2:0] F3_ST_MAX     = 3'b010;
  localparam logic [2:0] F3_BR_RSVD2   = 3'b010;
  localparam logic [2:0] F3_BR_RSVD3   = 3'b011;
  localparam logic [2:0] F3_JALR       = 3'b000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    opcode_t                   opcode;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      rs1Used;
    logic                      rs2Used;
    logic                      rdWe;
    logic                      illegal;
  } decoded_instr_t;

  // True for the RV32I base opcodes this decoder understands.
  function automatic logic isKnownOpcode(input logic [6:0] opc);
    logic known;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_IMM, OPC_OP: known = 1'b1;
      default:                              known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/idecoder_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the buffered decoder.
// slave is the decoder's view, master the view of whoever drives it.
interface idecoder_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  import idecoder_pipe_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_instr;
  logic [DATA_WIDTH-1:0]     in_pc;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_pc;
  opcode_t                   out_opcode;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic [REG_ADDR_WIDTH-1:0] out_rs1;
  logic [REG_ADDR_WIDTH-1:0] out_rs2;
  logic [2:0]                out_funct3;
  logic [6:0]                out_funct7;
  logic [DATA_WIDTH-1:0]     out_imm;
  logic                      out_rs1_used;
  logic                      out_rs2_used;
  logic                      out_rd_we;
  logic                      out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_rs1_used, out_rs2_used,
           out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_rs1_used, out_rs2_used,
           out_rd_we, out_illegal
  );

endinterface

// File: rtl/idecoder_pipe_idecode_core.sv
// Purely combinational RV32I field extractor and legality checker.
// Illegal words keep only pc and opcode so downstream never sees stale fields.
module idecode_core
  import idecoder_pipe_pkg::*;
#(
  parameter int ILLEGAL_CHECK = 1
) (
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output decoded_instr_t        o_dec
);

  logic [6:0]                w_opcode;
  logic [2:0]                w_funct3;
  logic [6:0]                w_funct7;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [REG_ADDR_WIDTH-1:0] w_rs1;
  logic [REG_ADDR_WIDTH-1:0] w_rs2;
  logic [DATA_WIDTH-1:0]     w_immI;
  logic [DATA_WIDTH-1:0]     w_immS;
  logic [DATA_WIDTH-1:0]     w_immB;
  logic [DATA_WIDTH-1:0]     w_immJ;
  logic [DATA_WIDTH-1:0]     w_immU;
  decoded_instr_t            w_fields;
  logic                      w_badFunct;
  logic                      w_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_rd     = i_instr[11:7];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];

  assign w_immI = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
  assign w_immS = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_immB = {{(DATA_WIDTH-13){i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_immJ = {{(DATA_WIDTH-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
  assign w_immU = {i_instr[31:12], 12'b0};

  // Per-format field extraction and funct legality, fields default to zero.
  always_comb begin
    w_fields        = '0;
    w_badFunct      = 1'b0;
    w_fields.pc     = i_pc;
    w_fields.opcode = opcode_t'(w_opcode);
    case (w_opcode)
      OPC_OP: begin
        w_fields.rd      = w_rd;
        w_fields.rs1     = w_rs1;
        w_fields.rs2     = w_rs2;
        w_fields.funct3  = w_funct3;
        w_fields.funct7  = w_funct7;
        w_fields.rs1Used = 1'b1;
        w_fields.rs2Used = 1'b1;
        w_fields.rdWe    = (w_rd != '0);
        if (w_funct7 != F7_BASE && w_funct7 != F7_ALT)
          w_badFunct = 1'b1;
        else if (w_funct7 == F7_ALT && w_funct3 != F3_ADD_SUB && w_funct3 != F3_SRL_SRA)
          w_badFunct = 1'b1;
      end
      OPC_IMM: begin
        w_fields.rd      = w_rd;
        w_fields.rs1     = w_rs1;
        w_fields.funct3  = w_funct3;
        w_fields.funct7  = w_funct7;
        w_fields.imm     = w_immI;
        w_fields.rs1Used = 1'b1;
        w_fields.rdWe    = (w_rd != '0);
        if (w_funct3 == F3_SLL && w_funct7 != F7_BASE)
          w_badFunct = 1'b1;
        else if (w_funct3 == F3_SRL_SRA && w_funct7 != F7_BASE && w_funct7 != F7_ALT)
          w_badFunct = 1'b1;
      end
      OPC_LOAD, OPC_JALR: begin
        w_fields.rd      = w_rd;
        w_fields.rs1     = w_rs1;
        w_fields.funct3  = w_funct3;
        w_fields.funct7  = w_funct7;
        w_fields.imm     = w_immI;
        w_fields.rs1Used = 1'b1;
        w_fields.rdWe    = (w_rd != '0);
        if (w_opcode == OPC_LOAD)
          w_badFunct = (w_funct3 == F3_LD_RSVD3) || (w_funct3 == F3_LD_RSVD6) ||
                       (w_funct3 == F3_LD_RSVD7);
        else
          w_badFunct = (w_funct3 != F3_JALR);
      end
      OPC_STORE: begin
        w_fields.rs1     = w_rs1;
        w_fields.rs2     = w_rs2;
        w_fields.funct3  = w_funct3;
        w_fields.imm     = w_immS;
        w_fields.rs1Used = 1'b1;
        w_fields.rs2Used = 1'b1;
        w_badFunct       = (w_funct3 > F3_ST_MAX);
      end
      OPC_BRANCH: begin
        w_fields.rs1     = w_rs1;
        w_fields.rs2     = w_rs2;
        w_fields.funct3  = w_funct3;
        w_fields.imm     = w_immB;
        w_fields.rs1Used = 1'b1;
        w_fields.rs2Used = 1'b1;
        w_badFunct       = (w_funct3 == F3_BR_RSVD2) || (w_funct3 == F3_BR_RSVD3);
      end
      OPC_JAL: begin
        w_fields.rd   = w_rd;
        w_fields.imm  = w_immJ;
        w_fields.rdWe = (w_rd != '0);
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fields.rd   = w_rd;
        w_fields.imm  = w_immU;
        w_fields.rdWe = (w_rd != '0);
      end
      default: ;
    endcase
  end

  assign w_illegal = (i_instr[1:0] != 2'b11) || !isKnownOpcode(w_opcode) ||
                     ((ILLEGAL_CHECK != 0) && w_badFunct);

  // Illegal words collapse to pc + opcode + illegal flag.
  always_comb begin
    o_dec = w_fields;
    if (w_illegal) begin
      o_dec         = '0;
      o_dec.pc      = w_fields.pc;
      o_dec.opcode  = w_fields.opcode;
      o_dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/idecoder_pipe.sv
// Buffered RV32I decoder: decodes on accept, stores results in an in-order
// queue and presents the head entry straight from its storage register.
// DATA_WIDTH/REG_ADDR_WIDTH must match the package widths used by the record.
module idecoder_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int QUEUE_DEPTH    = 2,
  parameter int ILLEGAL_CHECK  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  idecoder_pipe_if.slave        bus
);
  import idecoder_pipe_pkg::*;

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  decoded_instr_t     r_queue [QUEUE_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;

  decoded_instr_t     w_dec;
  decoded_instr_t     w_head;
  logic               w_inReady;
  logic               w_outValid;
  logic               w_push;
  logic               w_pop;

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  idecode_core #(
    .ILLEGAL_CHECK (ILLEGAL_CHECK)
  ) u_core (
    .i_instr (bus.in_instr),
    .i_pc    (bus.in_pc),
    .o_dec   (w_dec)
  );

  assign w_inReady  = (r_count < CNT_W'(QUEUE_DEPTH));
  assign w_outValid = (r_count != '0);
  assign w_push     = bus.in_valid && w_inReady && !i_flush;
  assign w_pop      = w_outValid && bus.out_ready;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= incPtr(r_wrPtr);
      if (w_pop)  r_rdPtr <= incPtr(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage, cleared on reset so the outputs read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_queue[i] <= '0;
    end else if (w_push) begin
      r_queue[r_wrPtr] <= w_dec;
    end
  end

  assign w_head = r_queue[r_rdPtr];

  assign bus.in_ready     = w_inReady;
  assign bus.out_valid    = w_outValid;
  assign bus.out_pc       = w_head.pc;
  assign bus.out_opcode   = w_head.opcode;
  assign bus.out_rd       = w_head.rd;
  assign bus.out_rs1      = w_head.rs1;
  assign bus.out_rs2      = w_head.rs2;
  assign bus.out_funct3   = w_head.funct3;
  assign bus.out_funct7   = w_head.funct7;
  assign bus.out_imm      = w_head.imm;
  assign bus.out_rs1_used = w_head.rs1Used;
  assign bus.out_rs2_used = w_head.rs2Used;
  assign bus.out_rd_we    = w_head.rdWe;
  assign bus.out_illegal  = w_head.illegal;

endmodule

// File: tb/tb_idecoder_pipe.sv
// Scoreboard bench for idecoder_pipe: two instances (full and relaxed
// illegal checks) see identical traffic; expected records are queued when an
// instruction is accepted and compared when the head entry is consumed.
module tb_idecoder_pipe;
  import idecoder_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  idecoder_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  idecoder_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus0 ();

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_instr  = bus.in_instr;
  assign bus0.in_pc     = bus.in_pc;
  assign bus0.out_ready = bus.out_ready;

  idecoder_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .QUEUE_DEPTH(2), .ILLEGAL_CHECK(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  idecoder_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .QUEUE_DEPTH(2), .ILLEGAL_CHECK(0)) dutNoCheck (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .bus     (bus0)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  decoded_instr_t expQ1 [$];
  decoded_instr_t expQ0 [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkDecoded(input string name, input decoded_instr_t act, input decoded_instr_t exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s pc=%h: got %h expected %h", name, exp.pc, act, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input logic [31:0] pc, input logic [6:0] opc,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm,
                                        input logic u1, input logic u2, input logic we,
                                        input logic ill);
    decoded_instr_t d;
    d.pc = pc; d.opcode = opcode_t'(opc); d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.funct3 = f3; d.funct7 = f7; d.imm = imm;
    d.rs1Used = u1; d.rs2Used = u2; d.rdWe = we; d.illegal = ill;
    return d;
  endfunction

  function automatic decoded_instr_t bad(input logic [31:0] pc, input logic [6:0] opc);
    return mk(pc, opc, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Monitor for the full-check instance.
  always @(negedge clk) begin
    decoded_instr_t act;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      act = mk(bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
               bus.out_funct3, bus.out_funct7, bus.out_imm, bus.out_rs1_used,
               bus.out_rs2_used, bus.out_rd_we, bus.out_illegal);
      if (expQ1.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedOut: got pc %h expected no entry", bus.out_pc);
      end else begin
        checkDecoded("dec", act, expQ1.pop_front());
      end
    end
  end

  // Monitor for the relaxed-check instance.
  always @(negedge clk) begin
    decoded_instr_t act;
    if (!rst && !flush && bus0.out_valid && bus0.out_ready) begin
      act = mk(bus0.out_pc, bus0.out_opcode, bus0.out_rd, bus0.out_rs1, bus0.out_rs2,
               bus0.out_funct3, bus0.out_funct7, bus0.out_imm, bus0.out_rs1_used,
               bus0.out_rs2_used, bus0.out_rd_we, bus0.out_illegal);
      if (expQ0.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedOutNoCheck: got pc %h expected no entry", bus0.out_pc);
      end else begin
        checkDecoded("decNoCheck", act, expQ0.pop_front());
      end
    end
  end

  // Present one instruction until accepted; returns one cycle after the accept edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input decoded_instr_t e1, input decoded_instr_t e0);
    bit accepted = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready && !flush) begin
        expQ1.push_back(e1);
        expQ0.push_back(e0);
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL acceptTimeout: got in_ready 0 for 20 cycles expected acceptance of pc %h", pc);
    end
  endtask

  task automatic applyBoth(input logic [31:0] instr, input logic [31:0] pc, input decoded_instr_t e);
    applyStimulus(instr, pc, e, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    #3;
    checkOutput("resetOutValid", 32'(bus.out_valid), 32'd0);
    idle(2);
    rst = 1'b0;
    #1;
    checkOutput("resetInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("resetOutPc", bus.out_pc, 32'd0);
    checkOutput("resetOutImm", bus.out_imm, 32'd0);
    checkOutput("resetOutIllegal", 32'(bus.out_illegal), 32'd0);

    // addi x1,x0,5 with single-cycle latency check
    bus.out_ready = 1'b1;
    applyBoth(32'h00500093, 32'h100,
              mk(32'h100, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 0, 1, 0));
    checkOutput("latencyOutValid", 32'(bus.out_valid), 32'd1);
    checkOutput("latencyOutPc", bus.out_pc, 32'h100);

    // streaming sw / beq / lui / jal
    applyBoth(32'h0020A423, 32'h104,
              mk(32'h104, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 1, 0, 0));
    applyBoth(32'hFE000EE3, 32'h108,
              mk(32'h108, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1, 1, 0, 0));
    applyBoth(32'h123452B7, 32'h10C,
              mk(32'h10C, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, 0, 1, 0));
    applyBoth(32'hFF9FF0EF, 32'h110,
              mk(32'h110, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFF8, 0, 0, 1, 0));
    idle(3);

    // backpressure: fill the two-entry queue, then drain while pushing a third
    bus.out_ready = 1'b0;
    applyBoth(32'h00100113, 32'h200,
              mk(32'h200, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 0, 1, 0));
    applyBoth(32'h002081B3, 32'h204,
              mk(32'h204, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 1, 1, 0));
    checkOutput("fullInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("fullHeadPc", bus.out_pc, 32'h200);
    bus.out_ready = 1'b1;
    applyBoth(32'h40118233, 32'h208,
              mk(32'h208, 7'h33, 5'd4, 5'd3, 5'd1, 3'd0, 7'h20, 32'd0, 1, 1, 1, 0));
    idle(3);

    // illegal encodings, relaxed instance only rejects the zero word
    applyBoth(32'h00000000, 32'h300, bad(32'h300, 7'h00));
    applyStimulus(32'h0000B003, 32'h304, bad(32'h304, 7'h03),
                  mk(32'h304, 7'h03, 5'd0, 5'd1, 5'd0, 3'd3, 7'd0, 32'd0, 1, 0, 0, 0));
    applyStimulus(32'h40001033, 32'h308, bad(32'h308, 7'h33),
                  mk(32'h308, 7'h33, 5'd0, 5'd0, 5'd0, 3'd1, 7'h20, 32'd0, 1, 1, 0, 0));
    idle(3);

    // flush with a full queue and a same-cycle input
    bus.out_ready = 1'b0;
    applyBoth(32'h00100113, 32'h400,
              mk(32'h400, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 0, 1, 0));
    applyBoth(32'h002081B3, 32'h404,
              mk(32'h404, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 1, 1, 0));
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00500093;
    bus.in_pc    = 32'h4FC;
    flush        = 1'b1;
    expQ1.delete();
    expQ0.delete();
    idle(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flushFullOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("flushFullInReady", 32'(bus.in_ready), 32'd1);

    // flush with one entry and an input that would otherwise be accepted
    applyBoth(32'h00100113, 32'h410,
              mk(32'h410, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 0, 1, 0));
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h123452B7;
    bus.in_pc    = 32'h4F8;
    flush        = 1'b1;
    expQ1.delete();
    expQ0.delete();
    idle(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flushOneOutValid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    applyBoth(32'h0020A423, 32'h420,
              mk(32'h420, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 1, 0, 0));
    idle(3);

    // asynchronous reset between edges while streaming
    applyBoth(32'h00500093, 32'h500,
              mk(32'h500, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 0, 1, 0));
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h123452B7;
    bus.in_pc    = 32'h504;
    #1;
    checkOutput("preResetOutValid", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    expQ1.delete();
    expQ0.delete();
    #1;
    checkOutput("asyncRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("asyncRstOutPc", bus.out_pc, 32'd0);
    checkOutput("asyncRstOutImm", bus.out_imm, 32'd0);
    checkOutput("asyncRstOutRd", 32'(bus.out_rd), 32'd0);
    checkOutput("asyncRstOutOpcode", 32'(bus.out_opcode), 32'd0);
    checkOutput("asyncRstOutRdWe", 32'(bus.out_rd_we), 32'd0);
    bus.in_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    #1;
    checkOutput("postRstInReady", 32'(bus.in_ready), 32'd1);
    applyBoth(32'h0020A423, 32'h600,
              mk(32'h600, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 1, 0, 0));
    idle(4);

    checkOutput("expQueueDrained", 32'(expQ1.size()), 32'd0);
    checkOutput("expQueueNoCheckDrained", 32'(expQ0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
